posit_divider: RTL and testbench

- Single-cycle posit divider: computes OUT = IN1 / IN2 for standard posit<N,ES> operands (default posit<32,2>).
- Inputs are decoded to sign, scale and significand; significands are divided; the quotient is re-encoded with posit round-to-nearest-even.
- Used as the divide unit of the posit processing unit.
- Datapath is combinational into one output register, so the result appears one clock after the operands are sampled.

---
 rtl/posit_divider_if.sv | 11 +
 rtl/posit_divider.sv | 125 ++++++++++++
 tb/tb_posit_divider.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_divider_if.sv
// Operand/result bundle for the posit divide unit: two operands in, one registered quotient out.
interface posit_divider_if #(
    parameter int N = 32
);
    logic [N-1:0] IN1;
    logic [N-1:0] IN2;
    logic [N-1:0] OUT;

    modport master (output IN1, output IN2, input OUT);
    modport slave  (input IN1, input IN2, output OUT);
endinterface

// File: rtl/posit_divider.sv
// Posit<N,ES> divider: combinational decode, significand divide and RNE re-encode into one
// output register, so each quotient appears one clock after its operands are sampled.
module posit_divider #(
    parameter int N  = 32,
    parameter int ES = 2
) (
    input  logic           clk,
    input  logic           rst,
    posit_divider_if.slave bus
);
    localparam int FW   = N - ES - 3;       // widest fraction field a posit can carry
    localparam int FB   = FW + 3;           // quotient fraction bits kept before rounding
    localparam int DW   = FW + FB + 2;
    localparam int L    = N + ES + FB;
    localparam int SW   = 16;
    localparam int MAXS = (N - 2) * (2 ** ES);
    localparam logic [N-1:0]         NAR = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [SW-1:0] ONE = 1;

    typedef struct packed {
        logic                 sgn;
        logic signed [SW-1:0] scale;
        logic [FW-1:0]        frac;
    } dec_t;

    function automatic dec_t decode(input logic [N-1:0] w);
        dec_t         d;
        logic [N-2:0] x;
        logic [N-2:0] y;
        logic         run;
        int           m;
        int           k;
        x   = w[N-1] ? (N-1)'(-w) : w[N-2:0];
        m   = 0;
        run = 1'b1;
        for (int i = N - 2; i >= 0; i--) begin
            if (run && (x[i] == x[N-2])) m++;
            else run = 1'b0;
        end
        // Dropping the regime and its terminator leaves exponent then fraction left-aligned.
        y       = x << (m + 1);
        k       = x[N-2] ? m - 1 : -m;
        d.sgn   = w[N-1];
        d.scale = SW'(k * (2 ** ES) + int'(y[N-2 -: ES]));
        d.frac  = FW'(y >> 2);
        return d;
    endfunction

    function automatic logic [N-1:0] encode(input logic sgn, input logic signed [SW-1:0] scale,
                                            input logic [FB-1:0] frac, input logic sticky);
        logic [N-2:0]         mag;
        logic [N-1:0]         regb;
        logic [L-1:0]         ext;
        logic signed [SW-1:0] sk;
        logic                 guard;
        logic                 st;
        int                   k;
        int                   r;
        regb  = '0;
        ext   = '0;
        guard = 1'b0;
        st    = 1'b0;
        sk    = scale >>> ES;
        k     = int'(sk);
        r     = 0;
        if (int'(scale) > MAXS) begin
            mag = '1;
        end else if (int'(scale) < -MAXS) begin
            mag = {{(N-2){1'b0}}, 1'b1};
        end else begin
            if (k >= 0) begin
                regb = ~({N{1'b1}} >> (k + 1));
                r    = k + 2;
            end else begin
                regb = NAR >> (-k);
                r    = 1 - k;
            end
            ext   = {regb, {(ES + FB){1'b0}}} | (L'({scale[ES-1:0], frac}) << (N - r));
            mag   = ext[L-1 -: N-1];
            guard = ext[L-N];
            st    = (|ext[L-N-1:0]) | sticky;
            if (guard && (st || mag[0])) mag = mag + 1'b1;
        end
        return sgn ? -{1'b0, mag} : {1'b0, mag};
    endfunction

    dec_t                 w_d1_p0;
    dec_t                 w_d2_p0;
    logic [DW-1:0]        w_num_p0;
    logic [DW-1:0]        w_den_p0;
    logic [FB+1:0]        w_q_p0;
    logic                 w_hi_p0;
    logic                 w_stk_p0;
    logic signed [SW-1:0] w_scale_p0;
    logic [FB-1:0]        w_frac_p0;
    logic [N-1:0]         w_res_p0;
    logic [N-1:0]         r_out_p1;

    // Stage p0: decode, divide significands, normalise, round; all combinational.
    always_comb begin
        w_d1_p0    = decode(bus.IN1);
        w_d2_p0    = decode(bus.IN2);
        w_num_p0   = {1'b1, w_d1_p0.frac, {(FB + 1){1'b0}}};
        w_den_p0   = DW'({1'b1, w_d2_p0.frac});
        w_q_p0     = (FB + 2)'(w_num_p0 / w_den_p0);
        w_hi_p0    = w_q_p0[FB+1];
        w_frac_p0  = w_hi_p0 ? w_q_p0[FB:1] : w_q_p0[FB-1:0];
        w_stk_p0   = ((w_num_p0 % w_den_p0) != '0) || (w_hi_p0 && w_q_p0[0]);
        w_scale_p0 = w_d1_p0.scale - w_d2_p0.scale - (w_hi_p0 ? '0 : ONE);
        if (bus.IN1 == NAR || bus.IN2 == NAR || bus.IN2 == '0)
            w_res_p0 = NAR;
        else if (bus.IN1 == '0)
            w_res_p0 = '0;
        else
            w_res_p0 = encode(w_d1_p0.sgn ^ w_d2_p0.sgn, w_scale_p0, w_frac_p0, w_stk_p0);
    end

    // Stage p1: output register.
    always_ff @(posedge clk) begin
        if (rst) r_out_p1 <= '0;
        else     r_out_p1 <= w_res_p0;
    end

    assign bus.OUT = r_out_p1;
endmodule

// File: tb/tb_posit_divider.sv
// Bench for posit_divider<32,2>: directed cases plus a random back-to-back stream against a
// bit-serial reference divide and bit-list posit encoder.
module tb_posit_divider;
    localparam logic [31:0] NAR = 32'h80000000;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    posit_divider_if #(.N(32)) bus();
    posit_divider #(.N(32), .ES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    function automatic void ref_decode(input logic [31:0] w, output bit neg, output int scale,
                                       output longint sig);
        logic [31:0] x;
        int          i;
        int          m;
        int          k;
        int          e;
        bit          first;
        neg   = w[31];
        x     = neg ? -w : w;
        first = x[30];
        m     = 0;
        i     = 30;
        while (i >= 0) begin
            if (x[i] != first) break;
            m++;
            i--;
        end
        i--;
        k = first ? m - 1 : -m;
        e = 0;
        for (int j = 0; j < 2; j++) begin
            e = e * 2 + ((i >= 0) ? int'(x[i]) : 0);
            i--;
        end
        sig = 1;
        for (int j = 0; j < 27; j++) begin
            sig = sig * 2 + ((i >= 0) ? longint'(x[i]) : 0);
            i--;
        end
        scale = 4 * k + e;
    endfunction

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        bit          na, nb, guard, sticky;
        int          sa, sb, scale, k, e;
        longint      ma, mb, rem;
        bit          bits[$];
        logic [30:0] mag;
        if (a == NAR || b == NAR || b == 32'h0) return NAR;
        if (a == 32'h0) return 32'h0;
        ref_decode(a, na, sa, ma);
        ref_decode(b, nb, sb, mb);
        if (ma >= mb) begin
            scale = sa - sb;
            rem   = ma - mb;
        end else begin
            scale = sa - sb - 1;
            rem   = 2 * ma - mb;
        end
        if (scale > 120) begin
            mag = 31'h7FFFFFFF;
        end else if (scale < -120) begin
            mag = 31'h1;
        end else begin
            e = ((scale % 4) + 4) % 4;
            k = (scale - e) / 4;
            if (k >= 0) begin
                repeat (k + 1) bits.push_back(1'b1);
                bits.push_back(1'b0);
            end else begin
                repeat (-k) bits.push_back(1'b0);
                bits.push_back(1'b1);
            end
            bits.push_back(e[1]);
            bits.push_back(e[0]);
            for (int j = 0; j < 40; j++) begin
                rem = rem * 2;
                if (rem >= mb) begin
                    bits.push_back(1'b1);
                    rem = rem - mb;
                end else begin
                    bits.push_back(1'b0);
                end
            end
            mag = '0;
            for (int j = 0; j < 31; j++) mag = {mag[29:0], bits[j]};
            guard  = bits[31];
            sticky = (rem != 0);
            for (int j = 32; j < bits.size(); j++) sticky = sticky | bits[j];
            if (guard && (sticky || mag[0])) mag = mag + 31'h1;
        end
        return (na ^ nb) ? -{1'b0, mag} : {1'b0, mag};
    endfunction

    task automatic step(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.IN1 = a;
        bus.IN2 = b;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bus.IN1 = 32'h48000000;
        bus.IN2 = 32'h40000000;
        @(negedge clk);
        checks++;
        if (bus.OUT !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", bus.OUT, 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.OUT !== 32'h48000000) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", bus.OUT, 32'h48000000);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.OUT !== 32'h0) begin
            errors++;
            $display("FAIL reset_dominates: got %h expected %h", bus.OUT, 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.OUT !== 32'h48000000) begin
            errors++;
            $display("FAIL reset_rerelease: got %h expected %h", bus.OUT, 32'h48000000);
        end
    endtask

    task automatic test_basic();
        logic [31:0] a[3];
        logic [31:0] b[3];
        logic [31:0] x[3];
        a = '{32'h4C000000, 32'h40000000, 32'h50000000};
        b = '{32'h48000000, 32'h48000000, 32'h48000000};
        x = '{32'h44000000, 32'h38000000, 32'h48000000};
        for (int i = 0; i < 3; i++) begin
            step(a[i], b[i]);
            checks++;
            if (bus.OUT !== x[i]) begin
                errors++;
                $display("FAIL basic %h/%h: got %h expected %h", a[i], b[i], bus.OUT, x[i]);
            end
        end
    endtask

    task automatic test_signs();
        logic [31:0] a[2];
        logic [31:0] b[2];
        logic [31:0] x[2];
        a = '{32'hC0000000, 32'hC0000000};
        b = '{32'h48000000, 32'hC0000000};
        x = '{32'hC8000000, 32'h40000000};
        for (int i = 0; i < 2; i++) begin
            step(a[i], b[i]);
            checks++;
            if (bus.OUT !== x[i]) begin
                errors++;
                $display("FAIL signs %h/%h: got %h expected %h", a[i], b[i], bus.OUT, x[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] a[4];
        logic [31:0] b[4];
        logic [31:0] x[4];
        a = '{32'h40000000, 32'h00000000, 32'h80000000, 32'h00000000};
        b = '{32'h00000000, 32'h48000000, 32'h40000000, 32'h00000000};
        x = '{32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000};
        for (int i = 0; i < 4; i++) begin
            step(a[i], b[i]);
            checks++;
            if (bus.OUT !== x[i]) begin
                errors++;
                $display("FAIL specials %h/%h: got %h expected %h", a[i], b[i], bus.OUT, x[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] a[3];
        logic [31:0] b[3];
        logic [31:0] x[3];
        a = '{32'h7FFFFFFF, 32'h00000001, 32'h80000001};
        b = '{32'h00000001, 32'h7FFFFFFF, 32'h00000001};
        x = '{32'h7FFFFFFF, 32'h00000001, 32'h80000001};
        for (int i = 0; i < 3; i++) begin
            step(a[i], b[i]);
            checks++;
            if (bus.OUT !== x[i]) begin
                errors++;
                $display("FAIL saturation %h/%h: got %h expected %h", a[i], b[i], bus.OUT, x[i]);
            end
        end
    endtask

    function automatic logic [31:0] pick_edge();
        logic [31:0] tbl[8];
        tbl = '{32'h00000000, NAR, 32'h7FFFFFFF, 32'h00000001,
                32'h80000001, 32'hFFFFFFFF, 32'h40000000, 32'hC0000000};
        return tbl[$urandom_range(0, 7)];
    endfunction

    function automatic logic [31:0] pick_simple();
        logic [31:0] tbl[5];
        tbl = '{32'h40000000, 32'h48000000, 32'h38000000, 32'h50000000, 32'h4C000000};
        return tbl[$urandom_range(0, 4)];
    endfunction

    task automatic test_back_to_back();
        logic [31:0] a, b, a_prev, b_prev, exp_prev;
        logic [31:0] fa[4];
        logic [31:0] fb[4];
        bit          have;
        int          mode;
        fa   = '{32'h40000000, 32'h40000000, 32'h3FFFFFFF, 32'h7FFFFFFE};
        fb   = '{32'h4C000000, 32'h5C000000, 32'h4C000000, 32'h48000000};
        have = 1'b0;
        a_prev = '0;
        b_prev = '0;
        exp_prev = '0;
        for (int i = 0; i <= 8200; i++) begin
            @(negedge clk);
            if (have) begin
                checks++;
                if (bus.OUT !== exp_prev) begin
                    errors++;
                    $display("FAIL stream[%0d] %h/%h: got %h expected %h",
                             i - 1, a_prev, b_prev, bus.OUT, exp_prev);
                end
            end
            if (i == 8200) break;
            if (i < 4) begin
                a = fa[i];
                b = fb[i];
            end else begin
                mode = $urandom_range(0, 9);
                a    = (mode == 0) ? pick_edge() : $urandom;
                b    = (mode == 1) ? pick_edge() : (mode < 4) ? pick_simple() : $urandom;
            end
            bus.IN1  = a;
            bus.IN2  = b;
            a_prev   = a;
            b_prev   = b;
            exp_prev = ref_div(a, b);
            have     = 1'b1;
        end
    endtask

    initial begin
        rst     = 1'b1;
        bus.IN1 = '0;
        bus.IN2 = '0;
        test_reset();
        test_basic();
        test_signs();
        test_specials();
        test_saturation();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
